// File: rtl/pic_icsp_reader.sv
// pic_icsp_reader
//   ICSP read-side master. On a start request it shifts a 6-bit "Read Data"
//   command out on PGD (LSB first), releases PGD, waits Tdly2 with PGC low,
//   then clocks in the PIC's 16-bit response frame (start, 14 data bits
//   LSB first, stop) and presents the 14-bit word on rdata with a done pulse.
//
//   Build option: define PIC_READER_AUTO_INC_EN to append an "Increment
//   Address" command (plus a second Tdly2 gap) after every read frame.
//
// Ports
//   clk_x    in   system clock
//   rst_n    in   synchronous active-low reset
//   start    in   read request, sampled only while idle
//   mem_sel  in   0 = program memory, 1 = data memory (captured with start)
//   busy     out  high from start-accept until done
//   done     out  one-cycle pulse, rdata valid
//   rdata    out  last word read, held until the next done
//   pgc      out  ICSP clock
//   pgd_out  out  PGD drive value
//   pgd_oe   out  PGD drive enable (0 = released)
//   pgd_in   in   PGD from pad, already synchronised
module pic_icsp_reader #(
    parameter int         CLK_DIV  = 10,
    parameter int         TDLY     = 20,
    parameter logic [5:0] CMD_PROG = 6'h04,
    parameter logic [5:0] CMD_DATA = 6'h05,
    parameter logic [5:0] CMD_INC  = 6'h06
) (
    input  logic        clk_x,
    input  logic        rst_n,
    input  logic        start,
    input  logic        mem_sel,
    output logic        busy,
    output logic        done,
    output logic [13:0] rdata,
    output logic        pgc,
    output logic        pgd_out,
    output logic        pgd_oe,
    input  logic        pgd_in
);

    localparam int DW = $clog2(CLK_DIV) + 1;
    localparam int TW = $clog2(TDLY) + 1;
    localparam logic [DW-1:0] DIV_RLD = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_ONE = DW'(1);
    localparam logic [TW-1:0] DLY_RLD = TW'(TDLY - 1);
    localparam logic [TW-1:0] DLY_ONE = TW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_DLY,
        S_DATA,
`ifdef PIC_READER_AUTO_INC_EN
        S_INC,
        S_DLY2,
`endif
        S_DONE
    } state_t;

    state_t        state_q;
    logic [DW-1:0] div_q;   // cycles left in the current pgc phase, minus one
    logic [TW-1:0] dly_q;   // cycles left in a Tdly2 gap, minus one
    logic [3:0]    cnt_q;   // bit cells still to be started
    logic [5:0]    sr_q;    // command bits not yet put on PGD
    logic [13:0]   rx_q;    // data bits collected so far
    logic          busy_q, done_q, pgc_q, pgd_out_q, pgd_oe_q;
    logic [13:0]   rdata_q;

`ifndef PIC_READER_AUTO_INC_EN
    logic unused_cmd_inc;
    assign unused_cmd_inc = ^CMD_INC;
`endif

    always_ff @(posedge clk_x) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            dly_q     <= '0;
            cnt_q     <= '0;
            sr_q      <= '0;
            rx_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pgc_q     <= 1'b0;
            pgd_out_q <= 1'b0;
            pgd_oe_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        sr_q      <= mem_sel ? CMD_DATA : CMD_PROG;
                        pgd_out_q <= mem_sel ? CMD_DATA[0] : CMD_PROG[0];
                        pgd_oe_q  <= 1'b1;
                        busy_q    <= 1'b1;
                        pgc_q     <= 1'b0;
                        // zero-length low phase: first high phase starts next edge
                        div_q     <= '0;
                        cnt_q     <= 4'd6;
                        state_q   <= S_CMD;
                    end
                end

`ifdef PIC_READER_AUTO_INC_EN
                S_CMD, S_INC: begin
`else
                S_CMD: begin
`endif
                    if (div_q != '0) begin
                        div_q <= div_q - DIV_ONE;
                    end else if (pgc_q) begin
                        pgc_q <= 1'b0;
                        div_q <= DIV_RLD;
                    end else if (cnt_q != 4'd0) begin
                        pgc_q     <= 1'b1;
                        div_q     <= DIV_RLD;
                        pgd_out_q <= sr_q[0];
                        sr_q      <= sr_q >> 1;
                        cnt_q     <= cnt_q - 4'd1;
                    end else begin
                        pgd_oe_q  <= 1'b0;
                        pgd_out_q <= 1'b0;
                        dly_q     <= DLY_RLD;
`ifdef PIC_READER_AUTO_INC_EN
                        state_q   <= (state_q == S_INC) ? S_DLY2 : S_DLY;
`else
                        state_q   <= S_DLY;
`endif
                    end
                end

                S_DLY: begin
                    if (dly_q != '0) begin
                        dly_q <= dly_q - DLY_ONE;
                    end else begin
                        // first data cell starts right at the end of the gap
                        pgc_q   <= 1'b1;
                        div_q   <= DIV_RLD;
                        cnt_q   <= 4'd15;
                        state_q <= S_DATA;
                    end
                end

                S_DATA: begin
                    if (div_q != '0) begin
                        div_q <= div_q - DIV_ONE;
                    end else if (pgc_q) begin
                        pgc_q <= 1'b0;
                        div_q <= DIV_RLD;
                        // cnt 14..1 are frame bits 1..14; start/stop are dropped
                        if (cnt_q != 4'd0 && cnt_q != 4'd15)
                            rx_q <= {pgd_in, rx_q[13:1]};
                    end else if (cnt_q != 4'd0) begin
                        pgc_q <= 1'b1;
                        div_q <= DIV_RLD;
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        rdata_q <= rx_q;
`ifdef PIC_READER_AUTO_INC_EN
                        pgc_q     <= 1'b1;
                        div_q     <= DIV_RLD;
                        pgd_oe_q  <= 1'b1;
                        pgd_out_q <= CMD_INC[0];
                        sr_q      <= CMD_INC >> 1;
                        cnt_q     <= 4'd5;
                        state_q   <= S_INC;
`else
                        done_q    <= 1'b1;
                        state_q   <= S_DONE;
`endif
                    end
                end

`ifdef PIC_READER_AUTO_INC_EN
                S_DLY2: begin
                    if (dly_q != '0) begin
                        dly_q <= dly_q - DLY_ONE;
                    end else begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
`endif

                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rdata   = rdata_q;
    assign pgc     = pgc_q;
    assign pgd_out = pgd_out_q;
    assign pgd_oe  = pgd_oe_q;

endmodule
